// File: rtl/intmul_rr_scheduler.sv
// Round-robin front end for one shared pipelined integer multiplier.
// Products come back in issue order, tagged with the requester ID that issued them.
module intmul_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int LOGA    = 34,
  parameter int LOGB    = 43,
  parameter int MUL_LAT = 3,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int INFW    = $clog2(MUL_LAT + 3)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*LOGA-1:0]   req_a,
  input  logic [NREQ*LOGB-1:0]   req_b,
  output logic [LOGA-1:0]        mul_a,
  output logic [LOGB-1:0]        mul_b,
  input  logic [LOGA+LOGB-1:0]   mul_c,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [LOGA+LOGB-1:0]   rsp_c,
  output logic [INFW-1:0]        inflight,
  output logic                   busy
);

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
  localparam logic [IDW:0]    NREQ_W   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);
  localparam logic [INFW-1:0] INF_MAX  = INFW'(MUL_LAT + 2);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic [IDW:0]   sum;
  logic           grant_found;
  logic           issue;
  logic           dec;
  logic [IDW-1:0] ptr_next;

  logic [MUL_LAT:0] sh_valid;
  logic [IDW-1:0]   sh_id [MUL_LAT+1];

  // Search ptr, ptr+1, ... with wrap; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      cand = sum[IDW-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign issue     = grant_found && !hold && !rst;
  assign req_ready = issue ? (ONE_HOT0 << grant_id) : '0;
  assign ptr_next  = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  assign dec       = |rsp_valid;
  assign busy      = (inflight != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      sh_valid  <= '0;
      for (int k = 0; k <= MUL_LAT; k++) sh_id[k] <= '0;
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_c     <= '0;
      inflight  <= '0;
    end else begin
      if (issue) begin
        ptr   <= ptr_next;
        mul_a <= req_a[int'(grant_id)*LOGA +: LOGA];
        mul_b <= req_b[int'(grant_id)*LOGB +: LOGB];
      end
      sh_valid[0] <= issue;
      sh_id[0]    <= grant_id;
      // The multiplier never stalls, so the tag pipeline shifts every cycle.
      for (int k = 1; k <= MUL_LAT; k++) begin
        sh_valid[k] <= sh_valid[k-1];
        sh_id[k]    <= sh_id[k-1];
      end
      rsp_valid <= sh_valid[MUL_LAT] ? (ONE_HOT0 << sh_id[MUL_LAT]) : '0;
      if (sh_valid[MUL_LAT]) begin
        rsp_id <= sh_id[MUL_LAT];
        rsp_c  <= mul_c;
      end
      unique case ({issue, dec})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  a_inflight_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(issue && !dec && inflight == INF_MAX));
  a_inflight_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec && !issue && inflight == '0));

endmodule

// File: tb/tb_intmul_rr_scheduler.sv
// Directed bench for intmul_rr_scheduler with a behavioural 3-stage multiplier.
module tb_intmul_rr_scheduler;
  localparam int NREQ = 4, LOGA = 34, LOGB = 43, MUL_LAT = 3, IDW = 2, INFW = 3;
  localparam int LOGC = LOGA + LOGB;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*LOGA-1:0] req_a;
  logic [NREQ*LOGB-1:0] req_b;
  logic [LOGA-1:0]      mul_a;
  logic [LOGB-1:0]      mul_b;
  logic [LOGC-1:0]      mul_c;
  logic [NREQ-1:0]      rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [LOGC-1:0]      rsp_c;
  logic [INFW-1:0]      inflight;
  logic                 busy;

  logic [LOGA-1:0] op_a [NREQ];
  logic [LOGB-1:0] op_b [NREQ];
  logic [LOGC-1:0] mpipe [MUL_LAT];

  always #5 clk = ~clk;

  intmul_rr_scheduler #(.NREQ(NREQ), .LOGA(LOGA), .LOGB(LOGB), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c), .inflight(inflight), .busy(busy)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[g*LOGA +: LOGA] = op_a[g];
    assign req_b[g*LOGB +: LOGB] = op_b[g];
  end

  // Shared multiplier: fixed latency, no enable.
  always_ff @(posedge clk) begin
    mpipe[0] <= LOGC'(mul_a) * LOGC'(mul_b);
    for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_c = mpipe[MUL_LAT-1];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       hold;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [3:0] rsp;
    int         infl;
  } vec_t;
  vec_t tbl[$];

  typedef struct {
    int              id;
    logic [LOGC-1:0] c;
  } exp_t;
  exp_t sb[$];

  function automatic void addv(logic h, logic [3:0] v, logic [3:0] r, logic [3:0] s, int n);
    vec_t e;
    e.hold = h; e.valid = v; e.ready = r; e.rsp = s; e.infl = n;
    tbl.push_back(e);
  endfunction

  function automatic int oh2id(logic [3:0] v);
    int r = 0;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic clear_inputs();
    hold = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_id", 128'(rsp_id), 128'(0));
    chk("rst_rsp_c", 128'(rsp_c), 128'(0));
    chk("rst_mul_a", 128'(mul_a), 128'(0));
    chk("rst_mul_b", 128'(mul_b), 128'(0));
    chk("rst_inflight", 128'(inflight), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [LOGC:0]   big_full;
  logic [LOGC-1:0] big_exp;
  exp_t            e;
  int              hit;

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Round robin, hold and wrap vectors.
    addv(0,4'hF,4'h1,4'h0,0); addv(0,4'hF,4'h2,4'h0,1); addv(0,4'hF,4'h4,4'h0,2);
    addv(0,4'hF,4'h8,4'h0,3); addv(0,4'hF,4'h1,4'h0,4); addv(0,4'hF,4'h2,4'h1,5);
    addv(0,4'hF,4'h4,4'h2,5); addv(0,4'hF,4'h8,4'h4,5); addv(0,4'h0,4'h0,4'h8,5);
    addv(0,4'h0,4'h0,4'h1,4); addv(0,4'h0,4'h0,4'h2,3); addv(0,4'h0,4'h0,4'h4,2);
    addv(0,4'h0,4'h0,4'h8,1); addv(0,4'h0,4'h0,4'h0,0);
    addv(0,4'hF,4'h1,4'h0,0); addv(0,4'hF,4'h2,4'h0,1); addv(1,4'hF,4'h0,4'h0,2);
    addv(1,4'hF,4'h0,4'h0,2); addv(1,4'hF,4'h0,4'h0,2); addv(0,4'hF,4'h4,4'h1,2);
    addv(0,4'h0,4'h0,4'h2,2); addv(0,4'h0,4'h0,4'h0,1); addv(0,4'h0,4'h0,4'h0,1);
    addv(0,4'h0,4'h0,4'h0,1); addv(0,4'h0,4'h0,4'h4,1); addv(0,4'h0,4'h0,4'h0,0);
    addv(0,4'h4,4'h4,4'h0,0); addv(0,4'hC,4'h8,4'h0,1); addv(0,4'hC,4'h4,4'h0,2);
    addv(0,4'h0,4'h0,4'h0,3); addv(0,4'h0,4'h0,4'h0,3); addv(0,4'h0,4'h0,4'h4,3);
    addv(0,4'h0,4'h0,4'h8,2); addv(0,4'h0,4'h0,4'h4,1); addv(0,4'h0,4'h0,4'h0,0);

    do_reset();
    for (int c = 0; c < tbl.size(); c++) begin
      @(posedge clk); #1;
      hold = tbl[c].hold;
      req_valid = tbl[c].valid;
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = LOGA'(c * 37 + i * 11 + 1) | (LOGA'(i + 1) << 30);
        op_b[i] = LOGB'(c * 53 + i * 7 + 3) | (LOGB'(c + 1) << 38);
      end
      @(negedge clk);
      chk("tbl_ready", 128'(req_ready), 128'(tbl[c].ready));
      chk("tbl_rsp_valid", 128'(rsp_valid), 128'(tbl[c].rsp));
      chk("tbl_inflight", 128'(inflight), 128'(tbl[c].infl));
      chk("tbl_busy", 128'(busy), 128'(tbl[c].infl != 0));
      if (tbl[c].rsp != 0) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL tbl_scoreboard: got response with no expected entry at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("tbl_rsp_id", 128'(rsp_id), 128'(e.id));
          chk("tbl_rsp_c", 128'(rsp_c), 128'(e.c));
        end
      end
      if (tbl[c].ready != 0) begin
        e.id = oh2id(tbl[c].ready);
        e.c  = LOGC'(op_a[e.id]) * LOGC'(op_b[e.id]);
        sb.push_back(e);
      end
    end

    // Single request: latency and inflight window.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      req_valid = (c == 0) ? 4'b0010 : 4'b0000;
      if (c == 0) begin op_a[1] = LOGA'(3); op_b[1] = LOGB'(5); end
      @(negedge clk);
      if (c == 0) chk("single_ready", 128'(req_ready), 128'(4'b0010));
      chk("single_rsp_valid", 128'(rsp_valid), 128'((c == 5) ? 4'b0010 : 4'b0000));
      if (c == 5) begin
        chk("single_rsp_id", 128'(rsp_id), 128'(1));
        chk("single_rsp_c", 128'(rsp_c), 128'(15));
      end
      chk("single_inflight", 128'(inflight), 128'((c >= 1 && c <= 5) ? 1 : 0));
    end

    // Full-width operands from requester 3.
    big_full = (78'd1 << 77) - (78'd1 << 43) - (78'd1 << 34) + 78'd1;
    big_exp  = big_full[LOGC-1:0];
    hit = -1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      req_valid = (c == 0) ? 4'b1000 : 4'b0000;
      if (c == 0) begin op_a[3] = '1; op_b[3] = '1; end
      @(negedge clk);
      if (c == 0) chk("big_ready", 128'(req_ready), 128'(4'b1000));
      if (hit < 0 && rsp_valid != 0) begin
        hit = c;
        chk("big_rsp_valid", 128'(rsp_valid), 128'(4'b1000));
        chk("big_rsp_id", 128'(rsp_id), 128'(3));
        chk("big_rsp_c", 128'(rsp_c), 128'(big_exp));
      end
    end
    chk("big_latency", 128'(hit), 128'(5));

    // Mid-cycle reset with three operations in flight.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 3) ? 4'b1111 : 4'b0000;
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = LOGA'(i + 2);
        op_b[i] = LOGB'(i + 9);
      end
      @(negedge clk);
      if (c < 3) chk("pre_rst_ready", 128'(req_ready), 128'(4'b0001 << c));
    end
    chk("pre_rst_rsp_valid", 128'(rsp_valid), 128'(4'b0001));
    chk("pre_rst_inflight", 128'(inflight), 128'(3));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("async_rst_inflight", 128'(inflight), 128'(0));
    chk("async_rst_busy", 128'(busy), 128'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < MUL_LAT + 4; c++) begin
      @(posedge clk); #1;
      req_valid = 4'b0000;
      @(negedge clk);
      chk("post_rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("post_rst_inflight", 128'(inflight), 128'(0));
    end
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("post_rst_ptr0", 128'(req_ready), 128'(4'b0001));
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("post_rst_inflight1", 128'(inflight), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
